// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with optional signed saturation.
// The carry chain is cut into STAGES segments; each stage adds one segment.
module carry_skip_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG  = WIDTH / ((STAGES < 1) ? 1 : STAGES);
  localparam int NBLK = SEG / ((BLOCK < 1) ? 1 : BLOCK);
  localparam int LAST = (STAGES < 1) ? 0 : STAGES - 1;

  if (STAGES < 1) begin : g_err_stages
    $error("carry_skip_adder_pipe: STAGES must be >= 1");
  end else if (BLOCK < 1 || (WIDTH % (BLOCK * STAGES)) != 0) begin : g_err_width
    $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLOCK*STAGES");
  end

  // One segment: ripple inside each block, block carry bypassed when all bits propagate.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
    logic [SEG-1:0] s;
    logic           c;
    logic           blk_ci;
    logic           prop;
    logic           pj;
    s = '0;
    c = ci;
    for (int bi = 0; bi < NBLK; bi++) begin
      blk_ci = c;
      prop   = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        pj                = a[bi*BLOCK+j] ^ b[bi*BLOCK+j];
        s[bi*BLOCK+j]     = pj ^ c;
        c                 = (a[bi*BLOCK+j] & b[bi*BLOCK+j]) | (pj & c);
        prop              = prop & pj;
      end
      c = prop ? blk_ci : c;
    end
    return {c, s};
  endfunction

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sat_q [STAGES];
  logic             v_q   [STAGES];
  logic             rdy   [STAGES];

  // A stage can load when it is empty or its contents move on this cycle.
  always_comb begin
    for (int k = 0; k < STAGES; k++) rdy[k] = 1'b0;
    rdy[LAST] = ~v_q[LAST] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
  end

  assign in_ready = rdy[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] s_prev;
    logic [WIDTH-1:0] s_d;
    logic             c_in;
    logic             sat_d;
    logic             v_d;
    logic [SEG:0]     seg_r;

    if (gi == 0) begin : g_first
      // Subtract folds into an add of the inverted operand and inverted borrow.
      assign a_d    = x;
      assign b_d    = sub ? ~y : y;
      assign c_in   = sub ? ~cin : cin;
      assign s_prev = '0;
      assign sat_d  = sat;
      assign v_d    = in_valid;
    end else begin : g_next
      assign a_d    = a_q[gi-1];
      assign b_d    = b_q[gi-1];
      assign c_in   = c_q[gi-1];
      assign s_prev = s_q[gi-1];
      assign sat_d  = sat_q[gi-1];
      assign v_d    = v_q[gi-1];
    end

    assign seg_r = seg_add(a_d[gi*SEG +: SEG], b_d[gi*SEG +: SEG], c_in);

    always_comb begin
      s_d                = s_prev;
      s_d[gi*SEG +: SEG] = seg_r[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[gi]   <= 1'b0;
        a_q[gi]   <= '0;
        b_q[gi]   <= '0;
        s_q[gi]   <= '0;
        c_q[gi]   <= 1'b0;
        sat_q[gi] <= 1'b0;
      end else if (rdy[gi]) begin
        v_q[gi] <= v_d;
        if (v_d) begin
          a_q[gi]   <= a_d;
          b_q[gi]   <= b_d;
          s_q[gi]   <= s_d;
          c_q[gi]   <= seg_r[SEG];
          sat_q[gi] <= sat_d;
        end
      end
    end
  end

  logic a_msb;
  logic b_msb;
  logic s_msb;
  logic raw_ovf;

  assign a_msb   = a_q[LAST][WIDTH-1];
  assign b_msb   = b_q[LAST][WIDTH-1];
  assign s_msb   = s_q[LAST][WIDTH-1];
  assign raw_ovf = (a_msb == b_msb) & (s_msb != a_msb);

  // Overflow direction follows the shared operand sign; reset state yields all zeros.
  assign out_valid = v_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = raw_ovf;
  assign sum       = (sat_q[LAST] & raw_ovf) ? {a_msb, {(WIDTH-1){~a_msb}}} : s_q[LAST];

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Randomised and directed check of carry_skip_adder_pipe against a signed/unsigned arithmetic model.
module tb_carry_skip_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    bit          lit;
    logic [31:0] ls;
    logic        lc;
    logic        lo;
    bit          lat;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  int          cyc = 0;
  bit          held = 1'b0;
  logic [33:0] hold_val = '0;
  bit          chk_lat = 1'b0;
  bit          cur_lit = 1'b0;
  logic [31:0] cur_ls = '0;
  logic        cur_lc = 1'b0;
  logic        cur_lo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // x + y + cin or x - y - cin, evaluated as plain integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb, input logic st);
    exp_t        e;
    logic [32:0] raw;
    longint      tr;
    if (!sb) begin
      raw = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      tr  = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    end else begin
      raw = {1'b0, a} - {1'b0, b} - {32'd0, ci};
      tr  = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
    end
    e     = '{default: '0};
    e.c   = sb ? ~raw[32] : raw[32];
    e.o   = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
    e.s   = raw[31:0];
    if (st && e.o) e.s = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_outputs", {30'd0, sum, cout, ovf}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {30'd0, sum, cout, ovf}, {30'd0, hold_val});
      end
      if (chk_lat && in_valid) chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got sum %h with no pending transaction (cycle %0d)", sum, cyc);
        end else begin
          e = q.pop_front();
          chk("sum", {32'd0, sum}, {32'd0, e.s});
          chk("cout", {63'd0, cout}, {63'd0, e.c});
          chk("ovf", {63'd0, ovf}, {63'd0, e.o});
          if (e.lit) begin
            chk("model_pin", {30'd0, e.s, e.c, e.o}, {30'd0, e.ls, e.lc, e.lo});
            chk("literal", {30'd0, sum, cout, ovf}, {30'd0, e.ls, e.lc, e.lo});
          end
          if (e.lat) chk("latency", 64'(cyc - e.t), 64'd2);
        end
      end
      held     = out_valid && !out_ready;
      hold_val = {sum, cout, ovf};
      if (in_valid && in_ready) begin
        e     = model(x, y, cin, sub, sat);
        e.lit = cur_lit;
        e.ls  = cur_ls;
        e.lc  = cur_lc;
        e.lo  = cur_lo;
        e.lat = chk_lat;
        e.t   = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
    cyc++;
  end

  task automatic junk_inputs();
    x   = $urandom;
    y   = $urandom;
    cin = 1'($urandom);
    sub = 1'($urandom);
    sat = 1'($urandom);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic sb, input logic st, input bit lit,
                      input logic [31:0] ls, input logic lc, input logic lo);
    int n;
    n        = 0;
    x        = a;
    y        = b;
    cin      = ci;
    sub      = sb;
    sat      = st;
    cur_lit  = lit;
    cur_ls   = ls;
    cur_lc   = lc;
    cur_lo   = lo;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cur_lit  = 1'b0;
    junk_inputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int ncyc;
    int target;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with literal expectations; out_ready held high throughout.
    chk_lat = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1, 32'h8000_0000, 1'b1, 1'b1);
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
    drain();
    chk_lat = 1'b0;

    // Back-pressure: four back-to-back inputs while the output is stalled.
    out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0033, 1'b0, 1'b0);
        send(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1, 32'h0000_00FE, 1'b1, 1'b0);
        send(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0010, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1, 32'h8000_0000, 1'b1, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight.
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Random traffic, with occasional operands that propagate on every bit.
    target = n_acc + 10000;
    ncyc   = 0;
    while (n_acc < target && ncyc < 60000) begin
      junk_inputs();
      if ($urandom_range(15) == 0) y = sub ? x : ~x;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
      ncyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (n_acc < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL random_budget: accepted %0d, expected %0d", n_acc, target);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
